tester_cycle_sequencer: RTL and testbench
=========================================

Name: tester_cycle_sequencer

Overview:
- Sequences the per-pin format registers of the ASIC tester.
- Generates the CYCLE strobe from a programmable test-cycle period and leading/trailing edge offsets, all counted in CLK ticks.
- Each test cycle it fetches one vector (drive data plus 2-bit format per pin) over a valid/ready handshake and presents it on D_OUT/FF_OUT.
- Sits between the vector memory/host interface and the bank of format flip-flop registers.

Parameters:
- PINS, 8, number of tester pins sequenced.
- CNT_W, 16, width of the period/offset counters and the cycle counter.

Ports:
- CLK  input  1  system clock; all timing is counted in CLK ticks.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  one-tick pulse; begins a run when IDLE, ignored otherwise.
- ABORT  input  1  stops the run; wins over all other inputs.
- PERIOD  input  CNT_W  test-cycle length in ticks; sampled on START.
- LEAD  input  CNT_W  leading-edge offset; sampled on START.
- TRAIL  input  CNT_W  trailing-edge offset; sampled on START.
- VEC_VALID  input  1  vector source has a vector.
- VEC_READY  output  1  sequencer accepts a vector this tick.
- VEC_DATA  input  PINS  drive data per pin.
- VEC_FMT  input  2*PINS  format per pin: 00 R0, 01 R1, 10 DNRZ_L, 11 DNRZ_T.
- VEC_LAST  input  1  accepted vector is the final one of the run.
- CYCLE  output  1  cycle strobe to the format registers.
- D_OUT  output  PINS  current vector data.
- FF_OUT  output  2*PINS  current vector formats.
- BUSY  output  1  run in progress.
- DONE  output  1  one-tick pulse when a run completes normally.
- CFG_ERR  output  1  sticky flag: timing configuration invalid.
- UNDERRUN  output  1  sticky flag: vector missing at a cycle boundary.
- CYCLE_COUNT  output  CNT_W  number of completed test cycles in the current/last run.

Behaviour:
- Reset (RST_N low, asynchronous):
  - All outputs 0, including D_OUT, FF_OUT, CYCLE_COUNT, CFG_ERR and UNDERRUN.
  - State IDLE; tick counter cnt = 0.
- States: IDLE, PRIME, RUN.
- IDLE:
  - BUSY=0, VEC_READY=0, CYCLE=0. D_OUT/FF_OUT hold their last values.
  - On START, configuration is valid only if PERIOD>=2 and LEAD<TRAIL and TRAIL<=PERIOD.
  - Invalid: CFG_ERR=1 on the next tick, stay IDLE.
  - Valid: latch PERIOD/LEAD/TRAIL; clear CFG_ERR, UNDERRUN and CYCLE_COUNT; go to PRIME.
- PRIME:
  - BUSY=1, VEC_READY=1.
  - On VEC_VALID: load VEC_DATA/VEC_FMT into D_OUT/FF_OUT; latch VEC_LAST into last_f; cnt=0; go to RUN.
  - No timeout; PRIME waits indefinitely.
- RUN:
  - cnt increments every tick, range 0..PERIOD-1.
  - CYCLE is driven directly from a flop and is high exactly during ticks where LEAD<=cnt<TRAIL. With LEAD=0 it is high on the first RUN tick. It is glitch-free.
  - VEC_READY=1 only on the tick where cnt==PERIOD-1 and last_f==0.
  - Boundary tick (cnt==PERIOD-1):
    - CYCLE_COUNT increments by 1. It wraps modulo 2^CNT_W; no flag.
    - If last_f==1: go to IDLE and pulse DONE for one tick. VEC_VALID is ignored.
    - Else if VEC_VALID: load the new vector, latch VEC_LAST into last_f, cnt=0, stay in RUN. This gives back-to-back cycles with no gap tick.
    - Else: UNDERRUN=1, go to IDLE, no DONE.
  - D_OUT/FF_OUT change only on a boundary load, or on the first load from PRIME. They are stable for the whole test cycle.
- ABORT:
  - Any state goes to IDLE on the next tick, with CYCLE=0 on that tick.
  - No DONE pulse; no flag changes; VEC_READY=0 that tick.
  - ABORT together with START is treated as ABORT.
- START while BUSY is ignored; latched configuration is unchanged.
- Configuration inputs may change freely during a run; only the values sampled on START are used.

Test Plan:
- Timing and formats: CLK 4 ns; PERIOD=25, LEAD=10, TRAIL=16; 3 vectors, last with VEC_LAST, VEC_VALID held high.
  - CYCLE is high at cnt 10..15 of each cycle, i.e. 40 ns and 64 ns into each 100 ns cycle.
  - Vectors pin0 D=0,1,0 with FMT=00 appear on D_OUT[0] at cycle starts 0, 100 and 200 ns.
  - DONE pulses once at the end; CYCLE_COUNT=3; BUSY drops.
- Configuration errors:
  - START with LEAD=16, TRAIL=10 gives CFG_ERR=1, BUSY=0, VEC_READY never high.
  - A following valid START clears CFG_ERR.
- Underrun: drop VEC_VALID for the 2nd boundary of a 4-vector run.
  - UNDERRUN=1, IDLE after exactly 2 cycles, CYCLE_COUNT=2, no DONE.
- Abort: assert ABORT at cnt=12 (CYCLE high).
  - Next tick CYCLE=0, BUSY=0, no DONE.
  - START during the run is ignored; PRIME stall (VEC_VALID low for 50 ticks) keeps BUSY=1 and CYCLE=0.
- Reset mid-run: RST_N low asynchronously at cnt=13.
  - CYCLE, D_OUT, FF_OUT and BUSY go to 0 immediately without waiting for CLK.
  - A fresh START after release runs normally.
- Edge cases: PERIOD=2, LEAD=0, TRAIL=2.
  - CYCLE is high continuously across back-to-back vectors.
  - VEC_READY is high only on cnt=1 ticks.

Source files
------------

// File: rtl/tester_cycle_sequencer.sv
// Purpose: sequences one pin vector per programmable test cycle and emits the CYCLE strobe between LEAD and TRAIL.
// Latency: the first vector appears one tick after it is accepted in PRIME; CYCLE is registered, with no combinational path.
// Backpressure: vec_ready is high in PRIME and on the boundary tick of a non-final cycle; a missing vector at a boundary ends the run as UNDERRUN.
//
// Ports: clk/rst_n (async active-low); start/abort control; period/lead/trail timing (sampled on start);
//        vec_valid/vec_ready/vec_data/vec_fmt/vec_last vector handshake; cycle/d_out/ff_out to format registers;
//        busy/done/cfg_err/underrun/cycle_count status.
module tester_cycle_sequencer #(
  parameter int PINS  = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   lead,
  input  logic [CNT_W-1:0]   trail,
  input  logic               vec_valid,
  output logic               vec_ready,
  input  logic [PINS-1:0]    vec_data,
  input  logic [2*PINS-1:0]  vec_fmt,
  input  logic               vec_last,
  output logic               cycle,
  output logic [PINS-1:0]    d_out,
  output logic [2*PINS-1:0]  ff_out,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic               underrun,
  output logic [CNT_W-1:0]   cycle_count
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   per_q, lead_q, trail_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               last_q, last_d;
  logic               cycle_q, cycle_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
  logic               underrun_q, underrun_d;
  logic [PINS-1:0]    d_q;
  logic [2*PINS-1:0]  ff_q;
  logic               load_vec, latch_cfg;
  logic               cfg_ok, boundary;

  assign cfg_ok   = (period >= CNT_W'(2)) && (lead < trail) && (trail <= period);
  assign boundary = (cnt_q == per_q - CNT_W'(1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    count_d    = count_q;
    last_d     = last_q;
    done_d     = 1'b0;
    cfg_err_d  = cfg_err_q;
    underrun_d = underrun_q;
    load_vec   = 1'b0;
    latch_cfg  = 1'b0;
    vec_ready  = 1'b0;
    if (abort) begin
      // abort beats everything: no load, no count, no flag update
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              latch_cfg  = 1'b1;
              cfg_err_d  = 1'b0;
              underrun_d = 1'b0;
              count_d    = '0;
              state_d    = PRIME;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        PRIME: begin
          vec_ready = 1'b1;
          if (vec_valid) begin
            load_vec = 1'b1;
            last_d   = vec_last;
            cnt_d    = '0;
            state_d  = RUN;
          end
        end
        RUN: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (boundary) begin
            count_d = count_q + CNT_W'(1);
            if (last_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              vec_ready = 1'b1;
              if (vec_valid) begin
                load_vec = 1'b1;
                last_d   = vec_last;
                cnt_d    = '0;
              end else begin
                underrun_d = 1'b1;
                state_d    = IDLE;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // strobe is computed from the next tick's count so the flop output lines up with cnt
    cycle_d = (state_d == RUN) && (cnt_d >= lead_q) && (cnt_d < trail_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      per_q      <= '0;
      lead_q     <= '0;
      trail_q    <= '0;
      count_q    <= '0;
      last_q     <= 1'b0;
      cycle_q    <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      underrun_q <= 1'b0;
      d_q        <= '0;
      ff_q       <= '0;
    end else begin
      cnt_q      <= cnt_d;
      count_q    <= count_d;
      last_q     <= last_d;
      cycle_q    <= cycle_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
      underrun_q <= underrun_d;
      if (latch_cfg) begin
        per_q   <= period;
        lead_q  <= lead;
        trail_q <= trail;
      end
      if (load_vec) begin
        d_q  <= vec_data;
        ff_q <= vec_fmt;
      end
    end
  end

  assign cycle       = cycle_q;
  assign d_out       = d_q;
  assign ff_out      = ff_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;
  assign underrun    = underrun_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_tester_cycle_sequencer.sv
// Purpose: directed checks of cycle timing, vector sequencing, config errors, underrun, abort and async reset.
// Latency: inputs driven and outputs sampled on the falling clock edge, one tick per rising edge.
// Backpressure: the bench offers vectors continuously except where a stall or underrun is being exercised.
`timescale 1ns/1ps
module tb_tester_cycle_sequencer;

  localparam int PINS  = 8;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CNT_W-1:0]  period = '0;
  logic [CNT_W-1:0]  lead = '0;
  logic [CNT_W-1:0]  trail = '0;
  logic              vec_valid = 1'b0;
  logic              vec_ready;
  logic [PINS-1:0]   vec_data = '0;
  logic [2*PINS-1:0] vec_fmt = '0;
  logic              vec_last = 1'b0;
  logic              cycle;
  logic [PINS-1:0]   d_out;
  logic [2*PINS-1:0] ff_out;
  logic              busy;
  logic              done;
  logic              cfg_err;
  logic              underrun;
  logic [CNT_W-1:0]  cycle_count;

  int n_vec  = 0;
  int n_miss = 0;

  logic [PINS-1:0]   vd [6];
  logic [2*PINS-1:0] vf [6];

  always #2 clk = ~clk;

  tester_cycle_sequencer #(.PINS(PINS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .period(period), .lead(lead), .trail(trail),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
    .vec_fmt(vec_fmt), .vec_last(vec_last), .cycle(cycle), .d_out(d_out),
    .ff_out(ff_out), .busy(busy), .done(done), .cfg_err(cfg_err),
    .underrun(underrun), .cycle_count(cycle_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, got, exp);
    end
  endtask

  // Full run from IDLE; drop >= 0 withholds the vector at that boundary index.
  task automatic do_run(input int nvec, input int per, input int ld, input int tr, input int drop);
    int ncyc;
    int c;
    int k;
    ncyc = (drop >= 0) ? drop + 1 : nvec;
    period = CNT_W'(per); lead = CNT_W'(ld); trail = CNT_W'(tr);
    start = 1'b1; vec_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("prime_busy", 32'(busy), 32'd1);
    chk("prime_rdy", 32'(vec_ready), 32'd1);
    chk("prime_cycle", 32'(cycle), 32'd0);
    chk("prime_cfgerr", 32'(cfg_err), 32'd0);
    chk("prime_underrun", 32'(underrun), 32'd0);
    chk("prime_count", 32'(cycle_count), 32'd0);
    vec_valid = 1'b1; vec_data = vd[0]; vec_fmt = vf[0]; vec_last = (nvec == 1);
    for (int i = 0; i < ncyc * per; i++) begin
      @(negedge clk);
      c = i / per;
      k = i % per;
      chk("run_cycle", 32'(cycle), 32'(k >= ld && k < tr));
      chk("run_dout", 32'(d_out), 32'(vd[c]));
      chk("run_ffout", 32'(ff_out), 32'(vf[c]));
      chk("run_count", 32'(cycle_count), 32'(c));
      chk("run_rdy", 32'(vec_ready), 32'(k == per - 1 && c < nvec - 1));
      chk("run_busy", 32'(busy), 32'd1);
      vec_data  = vd[c+1];
      vec_fmt   = vf[c+1];
      vec_last  = (c + 1 == nvec - 1);
      vec_valid = (c != drop);
    end
    @(negedge clk);
    vec_valid = 1'b0;
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_done", 32'(done), 32'(drop < 0));
    chk("end_count", 32'(cycle_count), 32'(ncyc));
    chk("end_underrun", 32'(underrun), 32'(drop >= 0));
    chk("end_cycle", 32'(cycle), 32'd0);
    chk("end_dout", 32'(d_out), 32'(vd[ncyc-1]));
    @(negedge clk);
    chk("end_done_off", 32'(done), 32'd0);
  endtask

  // Start a 25/10/16 run and stop at the negedge of RUN tick 'upto'.
  task automatic run_to(input int upto, input bit poke_start);
    period = 16'd25; lead = 16'd10; trail = 16'd16;
    start = 1'b1; vec_valid = 1'b1;
    vec_data = vd[0]; vec_fmt = vf[0]; vec_last = 1'b0;
    @(negedge clk);
    start = 1'b0;
    vec_data = vd[1]; vec_fmt = vf[1];
    for (int i = 0; i <= upto; i++) begin
      @(negedge clk);
      chk("pre_cycle", 32'(cycle), 32'(i >= 10 && i < 16));
      chk("pre_busy", 32'(busy), 32'd1);
      if (poke_start && i == 5) begin
        start = 1'b1; period = 16'd3; lead = 16'd0; trail = 16'd1;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    vd[0] = 8'h10; vf[0] = 16'hFFFC;
    vd[1] = 8'h21; vf[1] = 16'hAAA8;
    vd[2] = 8'h32; vf[2] = 16'h5554;
    vd[3] = 8'hC7; vf[3] = 16'h1E2D;
    vd[4] = 8'h5A; vf[4] = 16'h9B06;
    vd[5] = 8'hE9; vf[5] = 16'h3C71;

    // reset state
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cycle", 32'(cycle), 32'd0);
    chk("rst_rdy", 32'(vec_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfgerr", 32'(cfg_err), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_count", 32'(cycle_count), 32'd0);
    chk("rst_dout", 32'(d_out), 32'd0);
    chk("rst_ffout", 32'(ff_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // timing and formats: 100 ns cycles, strobe 40..64 ns
    do_run(3, 25, 10, 16, -1);

    // invalid configurations: swapped edges, short period, trail past period, empty window
    begin
      int bad [4][3] = '{'{25, 16, 10}, '{1, 0, 1}, '{10, 2, 11}, '{10, 5, 5}};
      for (int t = 0; t < 4; t++) begin
        period = CNT_W'(bad[t][0]); lead = CNT_W'(bad[t][1]); trail = CNT_W'(bad[t][2]);
        start = 1'b1; vec_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cfg_err_set", 32'(cfg_err), 32'd1);
        for (int j = 0; j < 3; j++) begin
          chk("cfg_busy", 32'(busy), 32'd0);
          chk("cfg_rdy", 32'(vec_ready), 32'd0);
          @(negedge clk);
        end
      end
      vec_valid = 1'b0;
    end

    // minimum period with strobe spanning the whole cycle; also clears cfg_err
    do_run(4, 2, 0, 2, -1);

    // underrun at the second boundary of a 4-vector run
    do_run(4, 25, 10, 16, 1);

    // abort mid-strobe, with a start poked during the run
    run_to(12, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_cycle", 32'(cycle), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rdy", 32'(vec_ready), 32'd0);
    chk("abort_count", 32'(cycle_count), 32'd0);
    @(negedge clk);
    chk("abort_done2", 32'(done), 32'd0);

    // PRIME stall keeps busy with no strobe, then abort out of it
    period = 16'd25; lead = 16'd0; trail = 16'd16;
    start = 1'b1; vec_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 50; j++) begin
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_cycle", 32'(cycle), 32'd0);
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("stall_abort_busy", 32'(busy), 32'd0);

    // abort together with start wins
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", 32'(busy), 32'd0);
    chk("abort_start_rdy", 32'(vec_ready), 32'd0);

    // asynchronous reset mid-strobe, between clock edges
    run_to(13, 1'b0);
    #1 rst_n = 1'b0;
    #0.5;
    chk("arst_cycle", 32'(cycle), 32'd0);
    chk("arst_dout", 32'(d_out), 32'd0);
    chk("arst_ffout", 32'(ff_out), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vec_valid = 1'b0;
    @(negedge clk);
    chk("arst_idle_busy", 32'(busy), 32'd0);

    // fresh run after reset
    do_run(2, 5, 1, 4, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
